gc_refresh_sched: RTL and testbench
===================================

# gc_refresh_sched

Refresh scheduler for the gain-cell DRAM array built from `MEM_WRAPPER` banks. It sits directly upstream of the wrappers and decides when each bank is refreshed. It walks the banks in a fixed ring. For each step it pulses the bank's `start_SR`, drives the per-bank `ref_en_current` (source bank) and `ref_en_old` (COI/destination bank) enables, and waits for the source bank's `ref_done`. A watchdog flags a refresh that does not complete.

## Interface
- `NUM_BANKS`, default 4: number of wrapper banks, at least 2.
- `RET_CYCLES`, default 1024: idle cycles between the end of one bank refresh and the next `start_SR`, at least 1.
- `TIMEOUT`, default 256: maximum cycles allowed in REFRESH before the error is raised, at least 1.
- `IDX_W`, default `$clog2(NUM_BANKS)`: bank index width.
- `clk` input, 1 bit: the single clock. All state changes on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `enable` input, 1 bit: run the refresh rotation.
- `ref_done` input, `NUM_BANKS` bits: per-bank `ref_done` from the wrappers.
- `start_sr` output, `NUM_BANKS` bits: one-hot, single-cycle pulse to the source bank's `start_SR`.
- `ref_en_cur` output, `NUM_BANKS` bits: one-hot, high on the source bank for the whole refresh.
- `ref_en_old` output, `NUM_BANKS` bits: one-hot, high on the COI bank, which is (src+1) mod `NUM_BANKS`.
- `src_idx` output, `IDX_W` bits: current source bank index.
- `busy` output, 1 bit: high in START and REFRESH.
- `timeout_err` output, 1 bit: sticky; set on watchdog expiry, cleared only by `rst`.
- `ref_count` output, 16 bits: number of completed bank refreshes, wraps at 2^16.

## Operation
- FSM states: IDLE, WAIT, START, REFRESH, ADVANCE.
- IDLE
  - All enables and `start_sr` are 0.
  - `enable`=1 moves to WAIT and clears the interval counter.
- WAIT
  - The interval counter increments each cycle.
  - When it reaches `RET_CYCLES`-1, the FSM moves to START.
  - `enable`=0 in WAIT returns to IDLE and clears the counter.
- START (exactly 1 cycle)
  - `start_sr[src]`=1.
  - `ref_en_cur[src]`=1 and `ref_en_old[(src+1)%N]`=1.
  - Watchdog is cleared.
  - Next state is REFRESH, unconditionally.
  - `ref_done` is ignored in this cycle, because the wrapper's SR is resetting.
- REFRESH
  - Enables stay as set in START; `start_sr`=0.
  - The watchdog increments each cycle.
  - `ref_done[src]`=1 moves to ADVANCE.
  - Watchdog reaching `TIMEOUT`-1 without done sets `timeout_err` and moves to ADVANCE. The bank is abandoned and `ref_count` is not incremented.
  - `ref_done` bits of non-source banks are ignored.
- ADVANCE (1 cycle)
  - All enables are 0.
  - `src_idx` ← (`src_idx`+1) mod `NUM_BANKS`. Wrap from `NUM_BANKS`-1 to 0; `NUM_BANKS` need not be a power of two.
  - `ref_count` increments if the exit was by done.
  - Next state is WAIT with the counter cleared if `enable`=1, otherwise IDLE.
- `enable` deasserted during START or REFRESH does not abort. The current bank finishes, or times out, before the FSM idles.
- Simultaneous `ref_done[src]` and watchdog expiry in the same cycle: done wins, no error, `ref_count` increments.
- Invariants:
  - At most one bit is set in each of `ref_en_cur`, `ref_en_old` and `start_sr`.
  - `ref_en_cur` and `ref_en_old` are never set on the same bank.

## Timing
- Reset values: state IDLE; `src_idx`=0; all of `start_sr`, `ref_en_cur`, `ref_en_old` are 0; `busy`=0; `timeout_err`=0; `ref_count`=0; both counters 0.
- Reset asserted mid-operation: on the next edge all outputs take their reset values, with no completion of the pending refresh.
- All outputs are registered. They change only on the rising edge after the state transition that causes them.
- Latency from `enable` rising to the `start_sr` pulse:
  - Edge 1 enters WAIT.
  - WAIT lasts `RET_CYCLES` cycles.
  - `start_sr` is high during cycle `RET_CYCLES`+1 after the sampling edge.
- Latency from `ref_done[src]` sampled high to enables low: 1 edge, into ADVANCE.
- `ref_count` and `src_idx` update on that same edge.
- Next `start_sr` follows `RET_CYCLES`+1 cycles after ADVANCE.
- A bank refresh occupies 1 START cycle plus between 1 and `TIMEOUT` REFRESH cycles.

## Test plan
- Reset then `enable`=1, with `RET_CYCLES`=4, N=4 and `ref_done` returned 3 cycles after each `start_sr`:
  - `start_sr` pulses go 0001, 0010, 0100, 1000, 0001.
  - `ref_en_old` goes 0010, 0100, 1000, 0001.
  - `ref_count`=4 after the full ring.
- Withhold `ref_done`, with `TIMEOUT`=8:
  - `busy` stays high for exactly 9 cycles (START plus 8).
  - `timeout_err`=1 and stays 1; `ref_count` is unchanged; `src_idx` advances.
- `ref_done[src]` asserted on the same cycle as the watchdog's last count: `timeout_err`=0 and `ref_count` increments.
- Spurious inputs: `ref_done` of a non-source bank high in REFRESH, and `ref_done[src]` high during START. Both are ignored and the FSM remains in REFRESH.
- Enable handling: drop `enable` during REFRESH and the bank completes, then the FSM goes to IDLE with all enables 0. Drop `enable` during WAIT and the FSM returns to IDLE with no `start_sr`.
- Assert `rst` mid-REFRESH on bank 2 with `ref_count`=5: next cycle all outputs are 0, `src_idx`=0 and `ref_count`=0. With N=3 the ring wraps 2 to 0.

Source files
------------

// File: rtl/gc_refresh_sched.sv
// gc_refresh_sched: ring-order refresh scheduler for MEM_WRAPPER banks, with a per-bank watchdog.
module gc_refresh_sched #(
  parameter int NUM_BANKS  = 4,
  parameter int RET_CYCLES = 1024,
  parameter int TIMEOUT    = 256,
  parameter int IDX_W      = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_BANKS-1:0] ref_done,
  output logic [NUM_BANKS-1:0] start_sr,
  output logic [NUM_BANKS-1:0] ref_en_cur,
  output logic [NUM_BANKS-1:0] ref_en_old,
  output logic [IDX_W-1:0]     src_idx,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [15:0]          ref_count
);
  localparam int CW = RET_CYCLES > 1 ? $clog2(RET_CYCLES) : 1;
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, WAIT, START, REFRESH, ADVANCE} state_t;
  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [WW-1:0]        r_wd;
  logic [IDX_W-1:0]     r_src;
  logic [NUM_BANKS-1:0] r_start, r_cur, r_old;
  logic                 r_busy, r_err;
  logic [15:0]          r_count;
  logic [IDX_W-1:0]     w_nxt;
  logic [NUM_BANKS-1:0] w_cur_oh, w_old_oh;
  logic                 w_done;
  // explicit wrap so non-power-of-two rings never reach an unused index
  assign w_nxt    = (r_src == IDX_W'(NUM_BANKS-1)) ? '0 : r_src + 1'b1;
  assign w_cur_oh = NUM_BANKS'(1) << r_src;
  assign w_old_oh = NUM_BANKS'(1) << w_nxt;
  assign w_done   = ref_done[r_src];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wd    <= '0;
      r_src   <= '0;
      r_start <= '0;
      r_cur   <= '0;
      r_old   <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: if (enable) begin
          r_state <= WAIT;
          r_cnt   <= '0;
        end
        WAIT: if (!enable) begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end else if (r_cnt == CW'(RET_CYCLES-1)) begin
          r_state <= START;
          r_start <= w_cur_oh;
          r_cur   <= w_cur_oh;
          r_old   <= w_old_oh;
          r_busy  <= 1'b1;
          r_wd    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        START: begin
          r_state <= REFRESH;
          r_start <= '0;
        end
        // done is checked first so it wins over a simultaneous watchdog expiry
        REFRESH: if (w_done || r_wd == WW'(TIMEOUT-1)) begin
          r_state <= ADVANCE;
          r_cur   <= '0;
          r_old   <= '0;
          r_busy  <= 1'b0;
          r_src   <= w_nxt;
          r_count <= w_done ? r_count + 1'b1 : r_count;
          r_err   <= r_err | ~w_done;
        end else begin
          r_wd <= r_wd + 1'b1;
        end
        ADVANCE: begin
          r_state <= enable ? WAIT : IDLE;
          r_cnt   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign start_sr    = r_start;
  assign ref_en_cur  = r_cur;
  assign ref_en_old  = r_old;
  assign src_idx     = r_src;
  assign busy        = r_busy;
  assign timeout_err = r_err;
  assign ref_count   = r_count;
endmodule

// File: tb/tb_gc_refresh_sched.sv
// tb_gc_refresh_sched: scoreboard bench; stimulus predicts each bank refresh, a monitor checks what the DUT shows.
module tb_gc_refresh_sched;
  localparam int N = 4, RET = 4, T = 8;
  logic clk = 0, rst, enable;
  logic [N-1:0] ref_done, start_sr, ref_en_cur, ref_en_old;
  logic [1:0] src_idx;
  logic busy, timeout_err;
  logic [15:0] ref_count;
  logic [2:0] ref_done3, start_sr3, ref_en_cur3, ref_en_old3;
  logic [1:0] src_idx3;
  logic busy3, timeout_err3;
  logic [15:0] ref_count3;
  int cyc = 0, errors = 0, checks = 0, trig = 0;
  int m_src = 0, m_count = 0, e3 = 0;
  bit m_err = 0;
  typedef struct {bit is_end; int cyc; int src; int cnt; bit err; int blen;} exp_t;
  exp_t q[$];

  gc_refresh_sched #(.NUM_BANKS(N), .RET_CYCLES(RET), .TIMEOUT(T)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .ref_done(ref_done), .start_sr(start_sr),
    .ref_en_cur(ref_en_cur), .ref_en_old(ref_en_old), .src_idx(src_idx), .busy(busy),
    .timeout_err(timeout_err), .ref_count(ref_count));

  // three-bank ring whose banks answer on their first refresh cycle
  gc_refresh_sched #(.NUM_BANKS(3), .RET_CYCLES(2), .TIMEOUT(4)) u_dut3 (
    .clk(clk), .rst(rst), .enable(1'b1), .ref_done(ref_done3), .start_sr(start_sr3),
    .ref_en_cur(ref_en_cur3), .ref_en_old(ref_en_old3), .src_idx(src_idx3), .busy(busy3),
    .timeout_err(timeout_err3), .ref_count(ref_count3));
  assign ref_done3 = ref_en_cur3 & ~start_sr3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk_reset;
    chk("rst_start_sr", start_sr, 0);
    chk("rst_en_cur", ref_en_cur, 0);
    chk("rst_en_old", ref_en_old, 0);
    chk("rst_src_idx", src_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_ref_count", ref_count, 0);
  endtask

  // r = cycles from start_sr to ref_done[src]; r > T means the bank never answers
  task automatic run_bank(input int r, input bit sp, input bit drop, input bit rmid);
    exp_t e;
    int s, rr, b;
    bit dn;
    s = trig + 1 + RET;
    rr = r < T ? r : T;
    dn = r <= T;
    b = m_src;
    e = '{0, s, b, 0, 0, 0};
    q.push_back(e);
    while (cyc < s) tick;
    ref_done = sp ? (oh(b) | oh((b + 1) % N)) : '0;
    if (rmid) begin
      tick;
      ref_done = '0;
      tick;
      tick;
      rst = 1;
      enable = 0;
      tick;
      chk_reset;
      tick;
      rst = 0;
      m_src = 0;
      m_count = 0;
      m_err = 0;
      return;
    end
    e = '{1, s + rr + 1, b, m_count + int'(dn), m_err | !dn, rr + 1};
    q.push_back(e);
    m_src = (b + 1) % N;
    m_count += int'(dn);
    m_err |= !dn;
    for (int k = 1; k <= rr; k++) begin
      tick;
      ref_done = sp ? ~oh(b) : '0;
      if (dn && k == r) ref_done[b] = 1;
      if (drop && k == 1) enable = 0;
    end
    tick;
    ref_done = '0;
    trig = cyc;
  endtask

  initial begin : monitor
    bit prev_busy;
    int blen, cur_src;
    exp_t e;
    prev_busy = 0;
    blen = 0;
    cur_src = 0;
    forever begin
      tick;
      if (rst) begin
        prev_busy = 0;
        blen = 0;
      end else begin
        chk("invariants", {28'd0, $onehot0(start_sr), $onehot0(ref_en_cur), $onehot0(ref_en_old),
            (ref_en_cur & ref_en_old) == 0}, 32'hf);
        if (busy) blen++;
        if (start_sr != 0) begin
          if (q.size() == 0 || q[0].is_end) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: got start_sr=%b expected none (cycle %0d)", start_sr, cyc);
          end else begin
            e = q.pop_front();
            cur_src = e.src;
            chk("start_cycle", cyc, e.cyc);
            chk("start_sr", start_sr, oh(e.src));
            chk("start_en_cur", ref_en_cur, oh(e.src));
            chk("start_en_old", ref_en_old, oh((e.src + 1) % N));
            chk("start_src_idx", src_idx, e.src);
            chk("start_busy", busy, 1);
          end
        end else if (busy) begin
          chk("hold_en_cur", ref_en_cur, oh(cur_src));
          chk("hold_en_old", ref_en_old, oh((cur_src + 1) % N));
        end
        if (prev_busy && !busy) begin
          if (q.size() == 0 || !q[0].is_end) begin
            checks++;
            errors++;
            $display("FAIL unexpected_end: got busy fall expected none (cycle %0d)", cyc);
          end else begin
            e = q.pop_front();
            chk("end_cycle", cyc, e.cyc);
            chk("end_src_idx", src_idx, (e.src + 1) % N);
            chk("end_ref_count", ref_count, e.cnt);
            chk("end_timeout_err", timeout_err, e.err);
            chk("busy_length", blen, e.blen);
            chk("end_en_cur", ref_en_cur, 0);
            chk("end_en_old", ref_en_old, 0);
          end
          blen = 0;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : monitor3
    forever begin
      tick;
      if (rst) e3 = 0;
      else if (start_sr3 != 0) begin
        chk("n3_start_sr", start_sr3, 3'(1) << e3);
        chk("n3_en_old", ref_en_old3, 3'(1) << ((e3 + 1) % 3));
        chk("n3_src_idx", src_idx3, e3);
        chk("n3_timeout_err", timeout_err3, 0);
        e3 = (e3 + 1) % 3;
      end
    end
  end

  initial begin
    rst = 1;
    enable = 0;
    ref_done = '0;
    repeat (3) tick;
    chk_reset;
    rst = 0;
    tick;
    enable = 1;
    trig = cyc;
    for (int i = 0; i < 4; i++) run_bank(3, 0, 0, 0);
    run_bank(T, 0, 0, 0);
    run_bank(T + 5, 1, 0, 0);
    run_bank(5, 0, 0, 1);
    enable = 1;
    trig = cyc;
    run_bank(int'($urandom_range(1, T)), 0, 1, 0);
    repeat (RET + 6) tick;
    chk("idle_after_drop_busy", busy, 0);
    chk("idle_after_drop_src", src_idx, m_src);
    enable = 1;
    tick;
    tick;
    enable = 0;
    repeat (RET + 6) tick;
    chk("wait_drop_busy", busy, 0);
    enable = 1;
    trig = cyc;
    for (int i = 0; i < 16; i++)
      run_bank(int'($urandom_range(1, T + 2)), bit'($urandom_range(0, 1)), i == 15, 0);
    repeat (RET + 6) tick;
    chk("queue_drained", q.size(), 0);
    chk("e3_progressed", e3 < 3 && ref_count3 > 16'd20, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
